// File: rtl/audio_transceiver_mc_if.sv
// Serial frame bus between the SPI/ADC source side and the transceiver core:
// frame select and data in, generated serial clock and processed samples out.
`timescale 1ns/1ps
interface audio_transceiver_mc_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16
);
  logic                         spi_mosi;
  logic                         spi_cs;
  logic                         serial_clk;
  logic [NUM_CH*SAMPLE_W-1:0]   sample_out;
  logic                         sample_valid;

  modport master (
    output spi_mosi, spi_cs,
    input  serial_clk, sample_out, sample_valid
  );

  modport slave (
    input  spi_mosi, spi_cs,
    output serial_clk, sample_out, sample_valid
  );
endinterface

// File: rtl/audio_transceiver_mc.sv
// Multi-channel audio transceiver: receives cs-framed MSB-first sample frames,
// double-buffers them, applies saturating Q1.7 gain with mute, drives per-channel PDM.
`timescale 1ns/1ps
module audio_transceiver_mc #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int CLK_DIV  = 4
) (
  input  logic                 input_clk,
  input  logic                 reset_n,
  audio_transceiver_mc_if.slave bus,
  input  logic [7:0]           volume,
  input  logic                 mute,
  output logic [NUM_CH-1:0]    dac_pdm_out,
  output logic                 RED_LED,
  output logic                 GREEN_LED,
  output logic                 BLUE_LED
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = $clog2(SAMPLE_W);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = SAMPLE_W + 9;

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("CLK_DIV must be even and >= 2");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_next;
  logic [DIV_W-1:0]       div_cnt;
  logic                   sclk_q, div_wrap, rise_en;
  logic [1:0]             cs_sync, mosi_sync;
  logic                   cs_s, mosi_s;
  logic [BIT_W-1:0]       bit_cnt;
  logic [CH_W-1:0]        ch_idx;
  logic [SAMPLE_W-1:0]    shift_reg, word_next;
  logic [SAMPLE_W-1:0]    staging [NUM_CH];
  logic [SAMPLE_W-1:0]    active  [NUM_CH];
  logic [7:0]             vol_q;
  logic                   done_q, load_q;
  logic                   start, cap, last_bit, last_word, abort;
  logic [NUM_CH*SAMPLE_W-1:0] gained, sample_q;
  logic                   valid_q, red_q, green_q, blue_q;

  // Serial clock divider; rise_en marks the edge that drives serial_clk 0->1.
  assign div_wrap = (div_cnt == DIV_W'(HALF - 1));
  assign rise_en  = div_wrap & ~sclk_q;

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
    end else if (div_wrap) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      div_cnt <= '0;
      sclk_q  <= ~sclk_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // NOTE: the cs synchroniser presets to the deasserted level so leaving reset never looks like a frame start.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0], bus.spi_cs};
      mosi_sync <= {mosi_sync[0], bus.spi_mosi};
    end
  end

  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign word_next = {shift_reg[SAMPLE_W-2:0], mosi_s};

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, otherwise latches are inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    cap        = 1'b0;
    last_bit   = 1'b0;
    last_word  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: if (!cs_s) begin
        state_next = SHIFT;
        start      = 1'b1;
      end
      SHIFT: begin
        if (rise_en) begin
          cap = 1'b1;
          if (bit_cnt == BIT_W'(SAMPLE_W - 1)) begin
            last_bit  = 1'b1;
            last_word = (ch_idx == CH_W'(NUM_CH - 1));
          end
        end
        // A final-bit capture wins over a simultaneous cs release.
        if (last_word) begin
          state_next = DONE;
        end else if (cs_s) begin
          state_next = IDLE;
          abort      = 1'b1;
          cap        = 1'b0;
          last_bit   = 1'b0;
        end
      end
      DONE:    if (cs_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: both sample banks are reset explicitly; they are small and reset must clear all state.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      ch_idx    <= '0;
      shift_reg <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        staging[c] <= '0;
        active[c]  <= '0;
      end
      vol_q  <= '0;
      done_q <= 1'b0;
      load_q <= 1'b0;
      red_q  <= 1'b0;
    end else begin
      done_q <= last_word;
      load_q <= done_q;
      if (abort) red_q <= 1'b1;
      if (start) begin
        bit_cnt <= '0;
        ch_idx  <= '0;
      end else if (cap) begin
        shift_reg <= word_next;
        if (last_bit) begin
          staging[ch_idx] <= word_next;
          bit_cnt         <= '0;
          ch_idx          <= ch_idx + CH_W'(1);
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
      if (done_q) begin
        active <= staging;
        vol_q  <= volume;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [PW-1:0] prod, scaled;
    logic [SAMPLE_W-1:0]  sat, dac_in, u, acc;
    logic [SAMPLE_W:0]    sum;
    logic                 pdm_q;

    // Floor of sample*volume/128, clamped when the bits above the sample width disagree with its sign.
    always_comb begin
      prod   = PW'($signed(active[c])) * PW'($signed({1'b0, vol_q}));
      scaled = prod >>> 7;
      if (scaled[PW-1:SAMPLE_W-1] == '0 || scaled[PW-1:SAMPLE_W-1] == '1)
        sat = scaled[SAMPLE_W-1:0];
      else if (scaled[PW-1])
        sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
      else
        sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    assign gained[c*SAMPLE_W +: SAMPLE_W] = sat;

    always_comb begin
      dac_in = blue_q ? '0 : sample_q[c*SAMPLE_W +: SAMPLE_W];
      u      = {~dac_in[SAMPLE_W-1], dac_in[SAMPLE_W-2:0]};
      sum    = {1'b0, acc} + {1'b0, u};
    end

    always_ff @(posedge input_clk or negedge reset_n) begin
      if (!reset_n) begin
        acc   <= '0;
        pdm_q <= 1'b0;
      end else begin
        acc   <= sum[SAMPLE_W-1:0];
        pdm_q <= sum[SAMPLE_W];
      end
    end
    assign dac_pdm_out[c] = pdm_q;
  end

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
      valid_q  <= 1'b0;
      green_q  <= 1'b0;
      blue_q   <= 1'b0;
    end else begin
      valid_q <= load_q;
      blue_q  <= mute;
      if (load_q) begin
        sample_q <= gained;
        green_q  <= ~green_q;
      end
    end
  end

  assign bus.serial_clk   = sclk_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign RED_LED          = red_q;
  assign GREEN_LED        = green_q;
  assign BLUE_LED         = blue_q;

endmodule

// File: tb/tb_audio_transceiver_mc.sv
// Randomised bench for audio_transceiver_mc: a frame-level model predicts outputs,
// a negedge compare process checks them every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_audio_transceiver_mc;
  localparam int NUM_CH = 2;
  localparam int SW     = 16;
  localparam int FW     = NUM_CH * SW;

  logic              input_clk = 1'b0;
  logic              reset_n   = 1'b0;
  logic [7:0]        volume    = 8'd128;
  logic              mute      = 1'b0;
  logic [NUM_CH-1:0] pdm;
  logic              red_led, green_led, blue_led;

  audio_transceiver_mc_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SW)) bus ();

  audio_transceiver_mc #(.NUM_CH(NUM_CH), .SAMPLE_W(SW), .CLK_DIV(4)) dut (
    .input_clk   (input_clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .volume      (volume),
    .mute        (mute),
    .dac_pdm_out (pdm),
    .RED_LED     (red_led),
    .GREEN_LED   (green_led),
    .BLUE_LED    (blue_led)
  );

  always #5 input_clk = ~input_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  longint      cyc     = 0;
  longint      exp_vcyc = -1;
  longint      mute_cyc = 0;
  logic        mute_prev = 1'b0;
  logic [FW-1:0] exp_out = '0, pending = '0;
  logic        exp_green = 1'b0, exp_red = 1'b0, red_dc = 1'b0;
  logic        checking = 1'b0;
  int          ones [NUM_CH];

  always @(posedge input_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    n_tests++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Gain model: floor(sample * volume / 128), clamped to the signed sample range.
  function automatic logic [SW-1:0] gain(input logic [SW-1:0] s, input logic [7:0] v);
    longint q, r, hi, lo;
    q  = longint'($signed(s)) * longint'(v);
    r  = (q >= 0) ? q / 128 : -((-q + 127) / 128);
    hi = (longint'(1) << (SW - 1)) - 1;
    lo = -(longint'(1) << (SW - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r[SW-1:0];
  endfunction

  // Channel 0 arrives first on the wire and lands in the low bits of sample_out.
  function automatic logic [FW-1:0] model_frame(input logic [FW-1:0] frame, input logic [7:0] v);
    logic [FW-1:0] o;
    o = '0;
    for (int c = 0; c < NUM_CH; c++)
      o[c*SW +: SW] = gain(frame[FW-1-c*SW -: SW], v);
    return o;
  endfunction

  always @(negedge input_clk) begin
    logic exp_v;
    if (reset_n && checking) begin
      exp_v = (cyc == exp_vcyc);
      if (exp_v) begin
        exp_out   = pending;
        exp_green = ~exp_green;
      end
      check("sample_valid", {63'd0, bus.sample_valid}, {63'd0, exp_v});
      check("sample_out", {32'd0, bus.sample_out}, {32'd0, exp_out});
      check("green_led", {63'd0, green_led}, {63'd0, exp_green});
      if (!red_dc) check("red_led", {63'd0, red_led}, {63'd0, exp_red});
      check("blue_led", {63'd0, blue_led}, {63'd0, (cyc > mute_cyc) ? mute : mute_prev});
    end
  end

  task automatic send_frame(input logic [FW-1:0] frame, input int nbits, input logic [7:0] vol);
    volume = vol;
    @(posedge bus.serial_clk); #1;
    bus.spi_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = (i < FW) ? frame[FW-1-i] : 1'($urandom);
      @(posedge bus.serial_clk); #1;
      if (i == FW - 1) begin
        pending  = model_frame(frame, vol);
        exp_vcyc = cyc + 2;
      end
    end
    bus.spi_cs = 1'b1;
    if (nbits < FW) begin
      red_dc = 1'b1;
      repeat (6) @(posedge input_clk);
      exp_red = 1'b1;
      red_dc  = 1'b0;
    end
    repeat (2) @(posedge bus.serial_clk);
  endtask

  task automatic set_mute(input logic v);
    @(posedge input_clk); #1;
    mute_prev = mute;
    mute      = v;
    mute_cyc  = cyc;
  endtask

  task automatic apply_reset();
    #3 reset_n = 1'b0;
    #1;
    check("reset_outputs",
          {25'd0, bus.serial_clk, bus.sample_out, bus.sample_valid, pdm, red_led, green_led, blue_led},
          64'd0);
    exp_out    = '0;
    exp_green  = 1'b0;
    exp_red    = 1'b0;
    exp_vcyc   = -1;
    bus.spi_cs = 1'b1;
    mute       = 1'b0;
    mute_prev  = 1'b0;
    repeat (3) @(posedge input_clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic check_sclk();
    time t0, t1, t2;
    @(posedge bus.serial_clk); t0 = $time;
    @(negedge bus.serial_clk); t1 = $time;
    @(posedge bus.serial_clk); t2 = $time;
    check("sclk_high_time", 64'(t1 - t0), 64'd20);
    check("sclk_period", 64'(t2 - t0), 64'd40);
  endtask

  task automatic count_pdm();
    for (int c = 0; c < NUM_CH; c++) ones[c] = 0;
    repeat (1024) begin
      @(negedge input_clk);
      for (int c = 0; c < NUM_CH; c++) ones[c] += int'(pdm[c]);
    end
  endtask

  function automatic int pdm_expect(input int c);
    logic [SW-1:0] d;
    longint u;
    d = blue_led ? '0 : exp_out[c*SW +: SW];
    u = longint'(d ^ (1 << (SW - 1)));
    return int'((u * 1024) >> SW);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] frame;
    logic [7:0]    vol;
    int            r, nb;

    bus.spi_cs   = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (3) @(posedge input_clk);
    #2 reset_n = 1'b1;
    checking = 1'b1;
    check_sclk();

    // Model pins against hand-computed values.
    check("pin_unity", {32'd0, model_frame(32'h4000_C000, 8'd128)}, 64'h0000_0000_C000_4000);
    check("pin_sat",   {32'd0, model_frame(32'h7000_9000, 8'd255)}, 64'h0000_0000_8000_7FFF);
    check("pin_floor", {32'd0, model_frame(32'h0101_FFFF, 8'd64)},  64'h0000_0000_FFFF_0080);

    // Reset in the middle of a frame.
    @(posedge bus.serial_clk); #1;
    bus.spi_cs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.spi_mosi = 1'($urandom);
      @(posedge bus.serial_clk); #1;
    end
    apply_reset();
    check_sclk();
    repeat (20) @(posedge input_clk);

    send_frame(32'h4000_C000, FW, 8'd128);
    repeat (4) @(posedge input_clk); #1;
    check("t2_sample_out", {32'd0, bus.sample_out}, 64'h0000_0000_C000_4000);
    check("t2_green", {63'd0, green_led}, 64'd1);
    check("t2_red", {63'd0, red_led}, 64'd0);

    send_frame(32'h7000_9000, FW, 8'd255);
    #1 check("t3_saturate", {32'd0, bus.sample_out}, 64'h0000_0000_8000_7FFF);
    send_frame(32'h0101_FFFF, FW, 8'd64);
    #1 check("t3_floor", {32'd0, bus.sample_out}, 64'h0000_0000_FFFF_0080);

    send_frame(32'($urandom), 20, 8'd128);
    #1 check("t4_hold", {32'd0, bus.sample_out}, 64'h0000_0000_FFFF_0080);
    check("t4_red_set", {63'd0, red_led}, 64'd1);
    send_frame(32'h1234_5678, FW, 8'd128);
    #1 check("t4_red_sticky", {63'd0, red_led}, 64'd1);

    send_frame(32'h4000_C000, FW, 8'd128);
    repeat (20) @(posedge input_clk);
    count_pdm();
    check_tol("t5_pdm_ch0_lit", ones[0], 768, 1);
    check_tol("t5_pdm_ch1_lit", ones[1], 256, 1);
    set_mute(1'b1);
    repeat (20) @(posedge input_clk);
    count_pdm();
    for (int c = 0; c < NUM_CH; c++) check_tol("t5_pdm_mute", ones[c], 512, 1);
    #1 check("t5_mute_sample", {32'd0, bus.sample_out}, 64'h0000_0000_C000_4000);
    set_mute(1'b0);

    send_frame(32'hABCD_1357, FW + 8, 8'd128);
    #1 check("t6_long_frame", {32'd0, bus.sample_out}, 64'h0000_0000_1357_ABCD);
    send_frame(32'h0F0F_F0F0, FW, 8'd128);
    #1 check("t6_next_frame", {32'd0, bus.sample_out}, 64'h0000_0000_F0F0_0F0F);

    for (int n = 0; n < 20; n++) begin
      frame = 32'($urandom);
      vol   = 8'($urandom_range(0, 255));
      r     = $urandom_range(0, 9);
      nb    = (r < 2) ? $urandom_range(1, FW - 1) : (r == 2) ? FW + $urandom_range(1, 8) : FW;
      if (r == 4) frame = 32'h8000_7FFF;
      if (r == 3) set_mute(~mute);
      send_frame(frame, nb, vol);
      if (n % 5 == 4) begin
        repeat (20) @(posedge input_clk);
        count_pdm();
        for (int c = 0; c < NUM_CH; c++) check_tol("rand_pdm", ones[c], pdm_expect(c), 1);
      end
    end

    repeat (10) @(posedge input_clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
